// File: rtl/tx_mux_pkg.sv
// tx_mux_pkg: shared widths, record layout and FSM encoding for the TX arbiter mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tx_mux_pkg;

  localparam int ADDR_W = 8;
  localparam int BS_W   = 8;
  localparam int TS_W   = 32;
  localparam int REC_W  = ADDR_W + BS_W + TS_W;

  // One trading record as handed to the UART serializer.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BS_W-1:0]   buysell;
    logic [TS_W-1:0]   timestamp;
  } tx_rec_t;

  // Issue sequencing: pick a record, pulse it out, then follow tx_busy.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tx_rec_fifo.sv
// tx_rec_fifo: single-clock record FIFO, one push and one pop per edge.
// Latency: a pushed record is at the head (empty_o low) the cycle after its edge; head data is combinational.
// Backpressure: push while full is ignored unless a pop lands on the same edge; pop while empty is ignored.
module tx_rec_fifo
  import tx_mux_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push_i,
  input  tx_rec_t push_dat_i,
  input  logic    pop_i,
  output tx_rec_t head_dat_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tx_rec_t     mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic [AW:0] wptr_d, rptr_d;
  logic        wr_en;
  logic        rd_en;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  assign wptr_d = wr_en ? (wptr_q + 1'b1) : wptr_q;
  assign rptr_d = rd_en ? (rptr_q + 1'b1) : rptr_q;

  assign head_dat_o = mem_q[rptr_q[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= push_dat_i;
    end
  end

endmodule

// File: rtl/tx_arb_mux.sv
// tx_arb_mux: per-channel record FIFOs drained round-robin into one UART TX serializer.
// Latency: push at edge t on an idle empty system gives tx_dv high in the cycle after edge t+2; >=4 cycles between pulses.
// Backpressure: tx_busy holds issue in IDLE and paces each record; pushes to a full FIFO are dropped and flagged in ovf.
module tx_arb_mux
  import tx_mux_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DEPTH    = 16,
  parameter int BUSY_TMO = 4,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_CH-1:0]        tx_dv_in,
  input  logic [ADDR_W*N_CH-1:0] tx_addr_in,
  input  logic [BS_W*N_CH-1:0]   tx_buysell_in,
  input  logic [TS_W*N_CH-1:0]   tx_timestamp_in,
  output logic [ADDR_W-1:0]      tx_addr,
  output logic [BS_W-1:0]        tx_buysell,
  output logic [TS_W-1:0]        tx_timestamp,
  output logic [CH_W-1:0]        tx_ch,
  output logic                   tx_dv,
  input  logic                   tx_busy,
  output logic [N_CH-1:0]        ovf,
  input  logic [N_CH-1:0]        ovf_clr
);

  localparam int TMO_W = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;

  tx_rec_t          push_rec [N_CH];
  tx_rec_t          head_rec [N_CH];
  logic [N_CH-1:0]  fifo_full;
  logic [N_CH-1:0]  fifo_empty;
  logic [N_CH-1:0]  pop_d;
  logic [N_CH-1:0]  ovf_drop;

  tx_state_e        state_q;
  logic [CH_W-1:0]  rr_q;
  logic [CH_W-1:0]  rr_d;
  logic [TMO_W-1:0] tmo_q;
  logic             tx_dv_q;
  tx_rec_t          rec_q;
  logic [CH_W-1:0]  ch_q;
  logic [N_CH-1:0]  ovf_q;

  logic             grant_vld;
  logic [CH_W-1:0]  grant_idx;
  logic             issue_ok;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign push_rec[k].addr      = tx_addr_in[ADDR_W*k +: ADDR_W];
    assign push_rec[k].buysell   = tx_buysell_in[BS_W*k +: BS_W];
    assign push_rec[k].timestamp = tx_timestamp_in[TS_W*k +: TS_W];

    tx_rec_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push_i     (tx_dv_in[k]),
      .push_dat_i (push_rec[k]),
      .pop_i      (pop_d[k]),
      .head_dat_o (head_rec[k]),
      .full_o     (fifo_full[k]),
      .empty_o    (fifo_empty[k])
    );
  end

  // Round-robin grant: first non-empty channel at or above rr_q, wrapping; the
  // loop runs downward so the smallest distance from rr_q is assigned last.
  always_comb begin : p_grant
    int              cand;
    logic [CH_W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      cand = int'(rr_q) + i;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      cand_idx = CH_W'(cand);
      if (!fifo_empty[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign issue_ok = (state_q == ST_IDLE) && grant_vld && !tx_busy;
  assign rr_d     = (grant_idx == CH_W'(N_CH - 1)) ? '0 : (grant_idx + 1'b1);

  // One-hot pop of the granted FIFO on the edge that leaves IDLE.
  always_comb begin
    pop_d = '0;
    if (issue_ok) begin
      pop_d[grant_idx] = 1'b1;
    end
  end

  // A push is lost only when the FIFO is full and is not being popped on that edge.
  assign ovf_drop = tx_dv_in & fifo_full & ~pop_d;

  // Issue sequencer with registered record, channel and valid-pulse outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      tmo_q   <= '0;
      tx_dv_q <= 1'b0;
      rec_q   <= '0;
      ch_q    <= '0;
    end else begin
      tx_dv_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (issue_ok) begin
            rec_q   <= head_rec[grant_idx];
            ch_q    <= grant_idx;
            rr_q    <= rr_d;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tx_dv_q <= 1'b1;
          tmo_q   <= '0;
          state_q <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (tx_busy) begin
            state_q <= ST_WAIT_LO;
          end else if (tmo_q == TMO_W'(BUSY_TMO - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow flags; a drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_drop | (ovf_q & ~ovf_clr);
    end
  end

  assign tx_addr      = rec_q.addr;
  assign tx_buysell   = rec_q.buysell;
  assign tx_timestamp = rec_q.timestamp;
  assign tx_ch        = ch_q;
  assign tx_dv        = tx_dv_q;
  assign ovf          = ovf_q;

endmodule
